// File: rtl/cmd_sched_mem_if.sv
// MCU/SPI load, delete and clear signals plus the emission port to the sync block,
// grouped for the timed-command scheduler.
interface cmd_sched_mem_if #(
  parameter int DEPTH = 256,
  parameter int TW    = 64,
  parameter int PW    = 274
);
  localparam int AW = $clog2(DEPTH);

  logic [TW-1:0] TIME;
  logic          SYS_TIME_UPDATE;
  logic          REQ_COMM;
  logic          WR_REQ;
  logic [TW-1:0] WR_TIME;
  logic [PW-1:0] WR_PAYLOAD;
  logic          WR_ACK;
  logic          WR_ERR;
  logic          DEL_REQ;
  logic [TW-1:0] DEL_TIME;
  logic          CLR_ALL;
  logic          DATA_WR;
  logic [TW-1:0] TIME_START_z;
  logic [PW-1:0] PAYLOAD_z;
  logic [AW:0]   CNT;
  logic          FULL;
  logic          EMPTY;
  logic          BUSY;

  modport master (
    output TIME, SYS_TIME_UPDATE, REQ_COMM, WR_REQ, WR_TIME, WR_PAYLOAD,
           DEL_REQ, DEL_TIME, CLR_ALL,
    input  WR_ACK, WR_ERR, DATA_WR, TIME_START_z, PAYLOAD_z, CNT, FULL, EMPTY, BUSY
  );

  modport slave (
    input  TIME, SYS_TIME_UPDATE, REQ_COMM, WR_REQ, WR_TIME, WR_PAYLOAD,
           DEL_REQ, DEL_TIME, CLR_ALL,
    output WR_ACK, WR_ERR, DATA_WR, TIME_START_z, PAYLOAD_z, CNT, FULL, EMPTY, BUSY
  );
endinterface

// File: rtl/cmd_sched_mem.sv
// Timed-command scheduler: stores up to DEPTH {time,payload} entries, arms the earliest
// future one and emits it to the sync block TIME_REZERV ticks ahead of its start time.
module cmd_sched_mem #(
  parameter int DEPTH       = 256,
  parameter int TW          = 64,
  parameter int PW          = 274,
  parameter int TIME_REZERV = 384
) (
  input logic            CLK,
  input logic            rst_n,
  cmd_sched_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = TW + PW;
  localparam logic [AW:0] ONE_C      = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW:0] SCAN_END_C = (AW+1)'(DEPTH + 1);
  localparam logic [TW:0] REZ_C      = (TW+1)'(TIME_REZERV);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_DELETE = 3'd2,
    ST_SCAN   = 3'd3,
    ST_FETCH  = 3'd4
  } state_t;

  state_t           state_r;
  logic [DW-1:0]    mem_r [DEPTH];
  logic [DW-1:0]    rd_data_r;
  logic [DEPTH-1:0] valid_r;
  logic [AW:0]      cnt_r;
  logic [AW:0]      idx_r;
  logic [AW-1:0]    pidx_r;
  logic [AW-1:0]    best_addr_r;
  logic [AW-1:0]    arm_addr_r;
  logic             pvld_r;
  logic             found_r;
  logic             armed_r;
  logic             need_scan_r;
  logic             time_flag_r;
  logic             req_flag_r;
  logic             del_pend_r;
  logic             clr_pend_r;
  logic [2:0]       sys_sh_r;
  logic [2:0]       req_sh_r;
  logic [TW-1:0]    t_ref_r;
  logic [TW-1:0]    best_time_r;
  logic [TW-1:0]    arm_time_r;
  logic [TW-1:0]    del_time_r;
  logic [TW-1:0]    del_key_r;
  logic [TW-1:0]    time_start_r;
  logic [PW-1:0]    arm_pay_r;
  logic [PW-1:0]    payload_r;
  logic             data_wr_r;
  logic             wr_ack_r;
  logic             wr_err_r;

  logic [TW:0]      sum_s;
  logic [TW-1:0]    lim_s;
  logic [TW-1:0]    rd_time_s;
  logic [AW-1:0]    free_s;
  logic [AW-1:0]    rd_addr_s;
  logic             full_s;
  logic             wr_ok_s;
  logic             we_s;
  logic             sys_edge_s;
  logic             req_edge_s;
  logic             time_hold_s;
  logic             emit_s;

  // Free-slot encoder, saturated due-window limit, RAM addressing and emission gating
  always_comb begin
    free_s = {AW{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free_s = valid_r[i] ? free_s : AW'(i);
    end
    sum_s      = {1'b0, bus.TIME} + REZ_C;
    lim_s      = sum_s[TW] ? {TW{1'b1}} : sum_s[TW-1:0];
    rd_time_s  = rd_data_r[DW-1:PW];
    full_s     = (cnt_r == DEPTH_C);
    wr_ok_s    = !full_s && (bus.WR_TIME > bus.TIME);
    we_s       = (state_r == ST_WRITE) && wr_ok_s;
    rd_addr_s  = ((state_r == ST_SCAN) && (idx_r == SCAN_END_C)) ? best_addr_r : idx_r[AW-1:0];
    sys_edge_s = (sys_sh_r == 3'b001);
    req_edge_s = (req_sh_r == 3'b001);
    // A reloaded TIME must not fire the armed entry before the purge scan has seen it
    time_hold_s = (bus.SYS_TIME_UPDATE && !sys_sh_r[0]) || sys_edge_s || time_flag_r;
    emit_s      = (state_r == ST_IDLE) && armed_r && !time_hold_s && (arm_time_r <= lim_s);
  end

  // Command RAM: one write port, registered read with one cycle of latency
  always_ff @(posedge CLK) begin
    if (we_s) begin
      mem_r[free_s] <= {bus.WR_TIME, bus.WR_PAYLOAD};
    end
    rd_data_r <= mem_r[rd_addr_s];
  end

  // Scheduler FSM, slot bookkeeping, pending-request latches and registered outputs
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      valid_r      <= {DEPTH{1'b0}};
      cnt_r        <= {(AW+1){1'b0}};
      idx_r        <= {(AW+1){1'b0}};
      pidx_r       <= {AW{1'b0}};
      best_addr_r  <= {AW{1'b0}};
      arm_addr_r   <= {AW{1'b0}};
      pvld_r       <= 1'b0;
      found_r      <= 1'b0;
      armed_r      <= 1'b0;
      need_scan_r  <= 1'b0;
      time_flag_r  <= 1'b0;
      req_flag_r   <= 1'b0;
      del_pend_r   <= 1'b0;
      clr_pend_r   <= 1'b0;
      sys_sh_r     <= 3'b000;
      req_sh_r     <= 3'b000;
      t_ref_r      <= {TW{1'b0}};
      best_time_r  <= {TW{1'b0}};
      arm_time_r   <= {TW{1'b0}};
      del_time_r   <= {TW{1'b0}};
      del_key_r    <= {TW{1'b0}};
      time_start_r <= {TW{1'b0}};
      arm_pay_r    <= {PW{1'b0}};
      payload_r    <= {PW{1'b0}};
      data_wr_r    <= 1'b0;
      wr_ack_r     <= 1'b0;
      wr_err_r     <= 1'b0;
    end else begin
      sys_sh_r  <= {sys_sh_r[1:0], bus.SYS_TIME_UPDATE};
      req_sh_r  <= {req_sh_r[1:0], bus.REQ_COMM};
      data_wr_r <= 1'b0;
      wr_ack_r  <= 1'b0;
      wr_err_r  <= 1'b0;
      pvld_r    <= 1'b0;
      pidx_r    <= idx_r[AW-1:0];
      if (bus.DEL_REQ) begin
        del_pend_r <= 1'b1;
        del_time_r <= bus.DEL_TIME;
      end
      if (bus.CLR_ALL) begin
        clr_pend_r <= 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          if (emit_s) begin
            time_start_r        <= arm_time_r;
            payload_r           <= arm_pay_r;
            data_wr_r           <= 1'b1;
            valid_r[arm_addr_r] <= 1'b0;
            cnt_r               <= cnt_r - ONE_C;
            armed_r             <= 1'b0;
            need_scan_r         <= 1'b1;
          end else if (clr_pend_r) begin
            valid_r    <= {DEPTH{1'b0}};
            cnt_r      <= {(AW+1){1'b0}};
            armed_r    <= 1'b0;
            clr_pend_r <= bus.CLR_ALL;
          end else if (del_pend_r) begin
            del_key_r  <= del_time_r;
            del_pend_r <= bus.DEL_REQ;
            armed_r    <= 1'b0;
            idx_r      <= {(AW+1){1'b0}};
            state_r    <= ST_DELETE;
          end else if (bus.WR_REQ && !wr_ack_r && !wr_err_r) begin
            // The ack/err guard stops a still-high WR_REQ from storing the same command twice
            state_r <= ST_WRITE;
          end else if (need_scan_r || time_flag_r || req_flag_r) begin
            t_ref_r     <= bus.TIME;
            idx_r       <= {(AW+1){1'b0}};
            found_r     <= 1'b0;
            need_scan_r <= 1'b0;
            time_flag_r <= 1'b0;
            req_flag_r  <= 1'b0;
            state_r     <= ST_SCAN;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_WRITE: begin
          if (wr_ok_s) begin
            valid_r[free_s] <= 1'b1;
            cnt_r           <= cnt_r + ONE_C;
            wr_ack_r        <= 1'b1;
            need_scan_r     <= 1'b1;
            armed_r         <= 1'b0;
          end else begin
            wr_err_r <= 1'b1;
          end
          state_r <= ST_IDLE;
        end

        ST_DELETE: begin
          if (idx_r < DEPTH_C) begin
            pvld_r <= 1'b1;
            idx_r  <= idx_r + ONE_C;
          end
          if (pvld_r && valid_r[pidx_r] && (rd_time_s == del_key_r)) begin
            valid_r[pidx_r] <= 1'b0;
            cnt_r           <= cnt_r - ONE_C;
          end
          if (idx_r == DEPTH_C) begin
            need_scan_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end

        ST_SCAN: begin
          if (idx_r < DEPTH_C) begin
            pvld_r <= 1'b1;
          end
          if (idx_r != SCAN_END_C) begin
            idx_r <= idx_r + ONE_C;
          end
          if (pvld_r && valid_r[pidx_r]) begin
            if (rd_time_s <= t_ref_r) begin
              valid_r[pidx_r] <= 1'b0;
              cnt_r           <= cnt_r - ONE_C;
            end else if (!found_r || (rd_time_s < best_time_r)) begin
              found_r     <= 1'b1;
              best_time_r <= rd_time_s;
              best_addr_r <= pidx_r;
            end
          end
          // Last cycle: the read port already addresses the winner for FETCH
          if (idx_r == SCAN_END_C) begin
            if (found_r) begin
              state_r <= ST_FETCH;
            end else begin
              armed_r <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
        end

        ST_FETCH: begin
          arm_time_r <= rd_time_s;
          arm_pay_r  <= rd_data_r[PW-1:0];
          arm_addr_r <= best_addr_r;
          armed_r    <= 1'b1;
          state_r    <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (sys_edge_s) begin
        time_flag_r <= 1'b1;
      end
      if (req_edge_s) begin
        req_flag_r <= 1'b1;
      end
    end
  end

  assign bus.WR_ACK       = wr_ack_r;
  assign bus.WR_ERR       = wr_err_r;
  assign bus.DATA_WR      = data_wr_r;
  assign bus.TIME_START_z = time_start_r;
  assign bus.PAYLOAD_z    = payload_r;
  assign bus.CNT          = cnt_r;
  assign bus.FULL         = full_s;
  assign bus.EMPTY        = (cnt_r == {(AW+1){1'b0}});
  assign bus.BUSY         = (state_r != ST_IDLE);
endmodule
